// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// 32-entry by N-bit register file for the CPU datapath. One synchronous write
// port fed by writeback, two combinational read ports feeding the ALU operand
// inputs. Register x0 has no storage and always reads zero.
//
// Optional build macro: REGFILE_BYPASS_EN
//   When defined, each read port forwards wr_data combinationally when it
//   addresses the register being written in the same cycle (never for x0,
//   never while rst is high). When undefined, no forwarding logic exists and
//   a read-during-write returns the old value until the rising edge.
//
// Parameters:
//   N        data width of every register and of the data ports
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      synchronous active-high reset, clears x1..x31, beats any write
//   wr_ena   write enable
//   wr_addr  write register index
//   wr_data  write data, stored verbatim
//   rd_addr0 read port 0 register index
//   rd_data0 read port 0 data (combinational)
//   rd_addr1 read port 1 register index
//   rd_data1 read port 1 data (combinational)
// -----------------------------------------------------------------------------

// 32:1 multiplexer, one per read port.
module mux32 #(
    parameter int N = 32
) (
    input  logic [31:0][N-1:0] data_in,
    input  logic [4:0]         sel,
    output logic [N-1:0]       data_out
);

    assign data_out = data_in[sel];

endmodule

module register_file #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [4:0]   rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [4:0]   rd_addr1,
    output logic [N-1:0] rd_data1
);

    // Flattened view of all 32 registers as seen by the read muxes.
    // Slot 0 is a constant zero rather than a storage element.
    logic [31:0][N-1:0] reg_view;
    logic [N-1:0]       mux_data0;
    logic [N-1:0]       mux_data1;

    assign reg_view[0] = '0;

    // One-hot write decode gated by wr_ena. Only x1..x31 get a decode line,
    // so a write to x0 simply has nowhere to land.
    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic         wr_sel;
            logic [N-1:0] x_reg;

            assign wr_sel = wr_ena && (wr_addr == 5'(gi));

            // Reset is checked first so it discards a coincident write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    x_reg <= '0;
                end else if (wr_sel) begin
                    x_reg <= wr_data;
                end
            end

            assign reg_view[gi] = x_reg;
        end
    endgenerate

    mux32 #(.N(N)) u_rd_mux0 (
        .data_in  (reg_view),
        .sel      (rd_addr0),
        .data_out (mux_data0)
    );

    mux32 #(.N(N)) u_rd_mux1 (
        .data_in  (reg_view),
        .sel      (rd_addr1),
        .data_out (mux_data1)
    );

`ifdef REGFILE_BYPASS_EN
    // Write-through forwarding: a port addressing the register being written
    // this cycle sees the incoming data immediately. x0 and reset cycles are
    // excluded so x0 stays zero and reset never leaks write data.
    logic bypass0;
    logic bypass1;

    assign bypass0 = wr_ena && !rst && (wr_addr != 5'd0) && (rd_addr0 == wr_addr);
    assign bypass1 = wr_ena && !rst && (wr_addr != 5'd0) && (rd_addr1 == wr_addr);

    assign rd_data0 = bypass0 ? wr_data : mux_data0;
    assign rd_data1 = bypass1 ? wr_data : mux_data1;
`else
    // No forwarding: a read-during-write returns the pre-edge contents.
    assign rd_data0 = mux_data0;
    assign rd_data1 = mux_data1;
`endif

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry by N-bit register file with one synchronous write port and two combinational read ports.
- Each read port is a mux32 instance selected by a 5-bit address. This block owns the storage and write decode that feed those muxes.
- Sits between the CPU decode/writeback stages and the ALU operand inputs.
- Register x0 is hardwired to zero.

Parameters:
- N, 32, data width of every register and of the write/read data ports.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- wr_ena  input  1  write enable
- wr_addr  input  5  write register index
- wr_data  input  N  write data
- rd_addr0  input  5  read port 0 register index
- rd_data0  output  N  read port 0 data, combinational
- rd_addr1  input  5  read port 1 register index
- rd_data1  output  N  read port 1 data, combinational

Behaviour:
- Clocking and reset:
  - Single clock domain (clk).
  - Reset is synchronous and active-high (rst), sampled on the clk rising edge.
- Storage:
  - 32 registers, x00..x31, each N bits.
  - x00 has no storage element; it always reads 0.
- Reset:
  - On a rising edge with rst=1, x01..x31 load 0.
  - Reset takes priority over any simultaneous write.
  - Reset mid-sequence discards a pending write in that cycle.
- Write:
  - On a rising edge with rst=0 and wr_ena=1, register[wr_addr] loads wr_data.
  - Exactly one register changes per write, selected by a 5:32 one-hot decoder gated by wr_ena.
  - wr_addr=0 with wr_ena=1: no state change (write silently dropped).
  - wr_ena=0: all registers hold.
- Read:
  - rd_dataK = register[rd_addrK]; pure combinational, zero-cycle latency.
  - Built from two mux32 instances with N passed through.
  - Both ports may select the same address, returning identical data.
  - rd_addrK=0 always yields 0.
- Read-during-write (base build):
  - A read of the address being written returns the OLD value during that cycle.
  - The new value appears after the rising edge.
- Output reset values:
  - rd_data0/rd_data1 are combinational, so no reset register exists on them.
  - After any reset edge, both read 0 for every address until written.
- Before the first reset, contents are X. Benches must reset before checking.
- Widths: no arithmetic; wr_data stored verbatim; no truncation or extension.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-through forwarding on each read port.
  - If wr_ena=1, rst=0, wr_addr!=0 and rd_addrK==wr_addr, then rd_dataK = wr_data combinationally in the same cycle.
  - Otherwise, normal read.
  - Bypass is never applied for address 0 and never while rst=1.
- Undefined:
  - No forwarding logic is synthesised.
  - Read-during-write returns the old value, as in Behaviour.

Test Plan:
- Reset clear: write 0xDEADBEEF to x05, then assert rst for 1 edge with wr_ena=1, wr_addr=7, wr_data=0x1 -> afterwards x05=0 and x07=0 (reset priority); all 32 addresses read 0 on both ports.
- Write/read all: after reset, write x_i = 0xA5A50000+i for i=1..31 on consecutive edges, then sweep rd_addr0 ascending and rd_addr1 descending -> each port returns 0xA5A50000+i for i!=0, and 0 for i=0.
- x0 immutable: wr_ena=1, wr_addr=0, wr_data=0xFFFFFFFF -> rd_data0 with rd_addr0=0 stays 0; x01..x31 unchanged.
- Write enable gating: x03=0x12345678, then wr_ena=0, wr_addr=3, wr_data=0x0BADF00D for 3 edges -> x03 still 0x12345678.
- Read-during-write: x09=0x11111111; set rd_addr0=rd_addr1=9, wr_ena=1, wr_addr=9, wr_data=0x22222222:
  - Base build -> both ports read 0x11111111 before the edge and 0x22222222 after it.
  - With REGFILE_BYPASS_EN -> both ports read 0x22222222 before the edge.
- Width parameter: instantiate with N=8; write x31=0xC3 -> rd_data1 with rd_addr1=31 returns 0xC3; other registers remain 0.
